// File: rtl/mux_2_1_arb_pkg.sv
// Shared types and constants for the 2:1 packet-locking arbiter/mux.
package mux_2_1_arb_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

endpackage

// File: rtl/mux_2_1_arb_rr_arb2.sv
// Two-way grant logic: free arbitration with a round-robin tiebreak while idle,
// fixed grant to the locked channel while a packet is in flight.
module rr_arb2
  import mux_2_1_arb_pkg::*;
(
  input  logic   v0,
  input  logic   v1,
  input  logic   prio,
  input  state_t state,
  output logic   gnt_valid,
  output logic   gnt
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt       = 1'b0;
    case (state)
      IDLE: begin
        gnt_valid = v0 || v1;
        gnt       = (v0 && v1) ? prio : v1;
      end
      // A locked channel keeps its grant even while its valid is low.
      LOCK0: begin
        gnt_valid = 1'b1;
        gnt       = 1'b0;
      end
      LOCK1: begin
        gnt_valid = 1'b1;
        gnt       = 1'b1;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt       = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mux_2_1_arb.sv
// Packet-aware 2:1 stream merge with a registered output stage; a channel
// holds the output from its first beat until its last beat is accepted.
module mux_2_1_arb
  import mux_2_1_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0_data,
  input  logic             i0_valid,
  input  logic             i0_last,
  output logic             i0_ready,
  input  logic [WIDTH-1:0] i1_data,
  input  logic             i1_valid,
  input  logic             i1_last,
  output logic             i1_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sel,
  output logic             o_valid,
  output logic             o_last,
  input  logic             o_ready
);

  state_t state_reg;
  logic   prio_reg;
  logic   load;
  logic   gnt_valid;
  logic   gnt;
  logic   acc0;
  logic   acc1;

  rr_arb2 u_arb (
    .v0        (i0_valid),
    .v1        (i1_valid),
    .prio      (prio_reg),
    .state     (state_reg),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  assign load     = !o_valid || o_ready;
  assign i0_ready = !rst && load && gnt_valid && !gnt;
  assign i1_ready = !rst && load && gnt_valid && gnt;
  assign acc0     = i0_valid && i0_ready;
  assign acc1     = i1_valid && i1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      prio_reg  <= 1'b0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_sel     <= 1'b0;
      o_last    <= 1'b0;
    end else begin
      // Payload only changes on an accepted beat; an empty load just drops valid.
      if (load) begin
        o_valid <= acc0 || acc1;
        if (acc0) begin
          o_data <= i0_data;
          o_sel  <= 1'b0;
          o_last <= i0_last;
        end else if (acc1) begin
          o_data <= i1_data;
          o_sel  <= 1'b1;
          o_last <= i1_last;
        end
      end

      case (state_reg)
        IDLE: begin
          if (acc0 && !i0_last)      state_reg <= LOCK0;
          else if (acc1 && !i1_last) state_reg <= LOCK1;
        end
        LOCK0:   if (acc0 && i0_last) state_reg <= IDLE;
        LOCK1:   if (acc1 && i1_last) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      // The channel that just finished a packet loses the next tie.
      if (acc0 && i0_last)      prio_reg <= 1'b1;
      else if (acc1 && i1_last) prio_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_2_1_arb.sv
// Directed bench for mux_2_1_arb: a small arbitration model predicts readies
// and o_valid each cycle, and a queue of accepted beats is checked at the output.
module tb_mux_2_1_arb;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] i0_data, i1_data;
  logic             i0_valid, i0_last, i0_ready;
  logic             i1_valid, i1_last, i1_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_sel, o_valid, o_last, o_ready;

  mux_2_1_arb #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .i0_data  (i0_data),
    .i0_valid (i0_valid),
    .i0_last  (i0_last),
    .i0_ready (i0_ready),
    .i1_data  (i1_data),
    .i1_valid (i1_valid),
    .i1_last  (i1_last),
    .i1_ready (i1_ready),
    .o_data   (o_data),
    .o_sel    (o_sel),
    .o_valid  (o_valid),
    .o_last   (o_last),
    .o_ready  (o_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 idle, 1 locked to i0, 2 locked to i1.
  int   m_st   = 0;
  logic m_prio = 1'b0;
  logic m_ov   = 1'b0;
  logic [WIDTH+1:0] sb[$];

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic tick();
    logic load, gv, g, er0, er1, a0, a1;
    logic [WIDTH+1:0] e;
    #1;
    load = !m_ov || o_ready;
    gv = 1'b0;
    g  = 1'b0;
    if (m_st == 1)      begin gv = 1'b1; g = 1'b0; end
    else if (m_st == 2) begin gv = 1'b1; g = 1'b1; end
    else if (i0_valid && i1_valid) begin gv = 1'b1; g = m_prio; end
    else if (i0_valid)  begin gv = 1'b1; g = 1'b0; end
    else if (i1_valid)  begin gv = 1'b1; g = 1'b1; end
    er0 = !rst && load && gv && !g;
    er1 = !rst && load && gv && g;
    chk("i0_ready", WIDTH'(i0_ready), WIDTH'(er0));
    chk("i1_ready", WIDTH'(i1_ready), WIDTH'(er1));
    chk("o_valid", WIDTH'(o_valid), WIDTH'(m_ov));
    if (!rst && m_ov && o_ready) begin
      total++;
      assert (sb.size() > 0)
      else begin
        bad++;
        $error("FAIL sb_empty observed=beat expected=none");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("o_data", o_data, e[WIDTH+1:2]);
        chk("o_sel", WIDTH'(o_sel), WIDTH'(e[1]));
        chk("o_last", WIDTH'(o_last), WIDTH'(e[0]));
        $display("beat out: data=%h sel=%0d last=%0d", o_data, o_sel, o_last);
      end
    end
    a0 = i0_valid && er0;
    a1 = i1_valid && er1;
    if (rst) begin
      m_st = 0; m_prio = 1'b0; m_ov = 1'b0;
      sb.delete();
    end else begin
      if (a0) sb.push_back({i0_data, 1'b0, i0_last});
      if (a1) sb.push_back({i1_data, 1'b1, i1_last});
      if (load) m_ov = a0 || a1;
      if (m_st == 0) begin
        if (a0 && !i0_last)      m_st = 1;
        else if (a1 && !i1_last) m_st = 2;
      end else if (m_st == 1 && a0 && i0_last) m_st = 0;
      else if (m_st == 2 && a1 && i1_last)     m_st = 0;
      if (a0 && i0_last)      m_prio = 1'b1;
      else if (a1 && i1_last) m_prio = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_o_valid", WIDTH'(o_valid), '0);
    chk("rst_o_data", o_data, '0);
    chk("rst_o_sel", WIDTH'(o_sel), '0);
    chk("rst_o_last", WIDTH'(o_last), '0);
  endtask

  task automatic drive(input logic v0, input logic [WIDTH-1:0] d0, input logic l0,
                       input logic v1, input logic [WIDTH-1:0] d1, input logic l1);
    i0_valid = v0; i0_data = d0; i0_last = l0;
    i1_valid = v1; i1_data = d1; i1_last = l1;
  endtask

  logic [WIDTH-1:0] hold_data;

  initial begin
    rst = 1'b1; o_ready = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    tick();
    chk_reset_outputs();
    rst = 1'b0;

    // Single-beat packet from i0.
    drive(1'b1, 8'hA5, 1'b1, 1'b0, '0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    tick();

    // Fresh reset, then both channels contend with single-beat packets.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    tick();

    // i0 3-beat packet with i1 waiting; i0 valid gap mid-packet keeps the lock.
    drive(1'b1, 8'h01, 1'b0, 1'b0, '0, 1'b0);
    tick();
    drive(1'b1, 8'h02, 1'b0, 1'b1, 8'h77, 1'b1);
    tick();
    drive(1'b0, 8'h02, 1'b0, 1'b1, 8'h77, 1'b1);
    tick();
    drive(1'b1, 8'h03, 1'b1, 1'b1, 8'h77, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 8'h77, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    tick();

    // Backpressure: hold o_ready low for 4 cycles with both inputs waiting.
    drive(1'b1, 8'h3C, 1'b1, 1'b0, '0, 1'b0);
    tick();
    drive(1'b1, 8'h4D, 1'b1, 1'b1, 8'h5E, 1'b1);
    o_ready = 1'b0;
    hold_data = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_o_data", o_data, hold_data);
      chk("bp_o_sel", WIDTH'(o_sel), '0);
    end
    o_ready = 1'b1;
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    tick();
    tick();

    // Reset during the 2nd beat of a locked i1 packet.
    drive(1'b0, '0, 1'b0, 1'b1, 8'hB1, 1'b0);
    tick();
    drive(1'b1, 8'hC0, 1'b1, 1'b1, 8'hB2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs();
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    tick();

    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
